// File: rtl/wash_phase_if.sv
// Signal bundle between the washing-machine controller and the phase timer.
// The controller side is master; the timer side is slave.
interface wash_phase_if #(
   parameter int CNT_W = 16
);
   logic             lock;
   logic             motor;
   logic             drain_valve;
   logic             drained;
   logic             cycle_timeout;
   logic             spin;
   logic             spin_motor;
   logic             fault;
   logic [2:0]       phase;
   logic [CNT_W-1:0] remaining;

   modport master (
      output lock, motor, drain_valve, drained,
      input  cycle_timeout, spin, spin_motor, fault, phase, remaining
   );

   modport slave (
      input  lock, motor, drain_valve, drained,
      output cycle_timeout, spin, spin_motor, fault, phase, remaining
   );
endinterface

// File: rtl/wash_phase_timer.sv
// Times the wash and spin phases and watchdogs draining for the washer controller.
// A shared prescaler produces ticks; a shared counter holds ticks left (or ticks spent draining).
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no cycle running, waiting for lock && motor
// S_WASH      | counting motor-on ticks down from WASH_TICKS
// S_WASH_DONE | wash time elapsed, cycle_timeout held until motor drops
// S_DRAIN     | counting drain ticks up towards DRAIN_MAX, watching drained
// S_SPIN      | spin motor on, counting down from SPIN_TICKS
// S_SPIN_DONE | spin finished, spin held until lock drops
// S_FAULT     | drain watchdog expired; held until reset
module wash_phase_timer #(
   parameter int TICK_DIV   = 1000,
   parameter int WASH_TICKS = 30,
   parameter int SPIN_TICKS = 10,
   parameter int DRAIN_MAX  = 20,
   parameter int CNT_W      = 16
) (
   input  logic         clk,
   input  logic         rst,
   wash_phase_if.slave  bus
);

   localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WASH      = 3'd1,
      S_WASH_DONE = 3'd2,
      S_DRAIN     = 3'd3,
      S_SPIN      = 3'd4,
      S_SPIN_DONE = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             cycle_timeout_q, cycle_timeout_d;
   logic             spin_q, spin_d;
   logic             spin_motor_q, spin_motor_d;
   logic             fault_q, fault_d;
   logic             run;
   logic             tick;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         pre_q           <= '0;
         remaining_q     <= '0;
         cycle_timeout_q <= 1'b0;
         spin_q          <= 1'b0;
         spin_motor_q    <= 1'b0;
         fault_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         pre_q           <= pre_d;
         remaining_q     <= remaining_d;
         cycle_timeout_q <= cycle_timeout_d;
         spin_q          <= spin_d;
         spin_motor_q    <= spin_motor_d;
         fault_q         <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      run     = 1'b0;
      tick    = (pre_q == PRE_LAST);

      // lock=0 is checked first in every running state so an abort beats any expiry.
      unique case (state_q)
         S_IDLE: begin
            if (bus.lock && bus.motor) begin
               state_d = S_WASH;
               cnt_d   = CNT_W'(WASH_TICKS);
            end
         end
         S_WASH: begin
            if (!bus.lock) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (bus.motor) begin
               run = 1'b1;
               if (tick) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = S_WASH_DONE;
                     cnt_d   = '0;
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
         end
         S_WASH_DONE: begin
            if (!bus.lock) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!bus.motor) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            if (!bus.lock) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (bus.drained) begin
               state_d = S_SPIN;
               cnt_d   = CNT_W'(SPIN_TICKS);
            end else if (bus.drain_valve) begin
               run = 1'b1;
               if (tick) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_d == CNT_W'(DRAIN_MAX)) begin
                     state_d = S_FAULT;
                     cnt_d   = '0;
                  end
               end
            end
         end
         S_SPIN: begin
            if (!bus.lock) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               run = 1'b1;
               if (tick) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = S_SPIN_DONE;
                     cnt_d   = '0;
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
         end
         S_SPIN_DONE: begin
            if (!bus.lock) begin
               state_d = S_IDLE;
            end
         end
         S_FAULT: begin
            cnt_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      pre_d = pre_q;
      if (run) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (state_d != state_q) begin
         pre_d = '0;
      end

      cycle_timeout_d = (state_d == S_WASH_DONE);
      spin_d          = (state_d == S_SPIN_DONE);
      spin_motor_d    = (state_d == S_SPIN);
      fault_d         = (state_d == S_FAULT);

      remaining_d = '0;
      if (state_d == S_WASH || state_d == S_SPIN) begin
         remaining_d = cnt_d;
      end else if (state_d == S_DRAIN) begin
         remaining_d = CNT_W'(DRAIN_MAX) - cnt_d;
      end
   end

   assign bus.phase         = state_q;
   assign bus.remaining     = remaining_q;
   assign bus.cycle_timeout = cycle_timeout_q;
   assign bus.spin          = spin_q;
   assign bus.spin_motor    = spin_motor_q;
   assign bus.fault         = fault_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer with a short tick divider so whole cycles run quickly.
// Expected values are queued when stimulus is driven and checked once the DUT has responded.
module tb_wash_phase_timer;

   localparam int TICK_DIV   = 4;
   localparam int WASH_TICKS = 3;
   localparam int SPIN_TICKS = 2;
   localparam int DRAIN_MAX  = 2;
   localparam int CNT_W      = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   wash_phase_if #(.CNT_W(CNT_W)) wif ();

   wash_phase_timer #(
      .TICK_DIV   (TICK_DIV),
      .WASH_TICKS (WASH_TICKS),
      .SPIN_TICKS (SPIN_TICKS),
      .DRAIN_MAX  (DRAIN_MAX),
      .CNT_W      (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (wif)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_run  = 0;
   int  n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_v();
      return {9'd0, wif.fault, wif.spin_motor, wif.spin, wif.cycle_timeout, wif.phase, wif.remaining};
   endfunction

   function automatic logic [31:0] exp_v(input logic f, input logic sm, input logic s, input logic ct,
                                         input logic [2:0] ph, input logic [15:0] rem);
      return {9'd0, f, sm, s, ct, ph, rem};
   endfunction

   task automatic push(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_run++;
         n_fail++;
         $display("FAIL sb_underflow: got output with no expectation queued");
      end else begin
         e = sb_q.pop_front();
         check_eq(e.tag, obs, e.exp);
      end
   endtask

   // Queue the expectation, let n edges pass, then compare the full output vector.
   task automatic step_check(input string tag, input int n, input logic [31:0] exp);
      push(tag, exp);
      repeat (n) @(posedge clk);
      #1;
      pop_check(obs_v());
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic sel_sig(input int which);
      case (which)
         0:       return wif.cycle_timeout;
         1:       return wif.spin;
         default: return wif.fault;
      endcase
   endfunction

   // Counts edges until the selected output rises (-1 if it never does within limit).
   // Optionally drops motor after edge pause_at for pause_len edges.
   task automatic wait_rise(input string tag, input int which, input int limit,
                            input int pause_at, input int pause_len, input int exp_edges);
      int got;
      got = -1;
      push(tag, 32'(exp_edges));
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (pause_at != 0 && k == pause_at) wif.motor = 1'b0;
         if (pause_at != 0 && k == pause_at + pause_len) wif.motor = 1'b1;
         if (sel_sig(which)) begin
            got = k;
            break;
         end
      end
      pop_check(32'(got));
   endtask

   task automatic do_reset(input string tag);
      #3;
      rst             = 1'b0;
      wif.lock        = 1'b0;
      wif.motor       = 1'b0;
      wif.drain_valve = 1'b0;
      wif.drained     = 1'b0;
      step_check(tag, 0, exp_v(0, 0, 0, 0, 3'd0, 16'd0));
      @(negedge clk);
      rst = 1'b1;
      step(1);
   endtask

   task automatic to_wash();
      wif.lock  = 1'b1;
      wif.motor = 1'b1;
      step(1);
   endtask

   initial begin
      wif.lock        = 1'b0;
      wif.motor       = 1'b0;
      wif.drain_valve = 1'b0;
      wif.drained     = 1'b0;
      step(2);
      step_check("reset_state", 0, exp_v(0, 0, 0, 0, 3'd0, 16'd0));
      @(negedge clk);
      rst = 1'b1;
      step_check("idle_hold", 2, exp_v(0, 0, 0, 0, 3'd0, 16'd0));

      // Normal cycle
      wif.lock  = 1'b1;
      wif.motor = 1'b1;
      step_check("wash_entry", 1, exp_v(0, 0, 0, 0, 3'd1, 16'd3));
      step_check("wash_tick1", 4, exp_v(0, 0, 0, 0, 3'd1, 16'd2));
      wait_rise("wash_edges", 0, 40, 0, 0, 8);
      step_check("wash_done", 0, exp_v(0, 0, 0, 1, 3'd2, 16'd0));
      step_check("wash_done_hold", 2, exp_v(0, 0, 0, 1, 3'd2, 16'd0));
      wif.motor = 1'b0;
      step_check("drain_entry", 1, exp_v(0, 0, 0, 0, 3'd3, 16'd2));
      step_check("drain_valve_off", 6, exp_v(0, 0, 0, 0, 3'd3, 16'd2));
      wif.drained = 1'b1;
      step_check("spin_entry", 1, exp_v(0, 1, 0, 0, 3'd4, 16'd2));
      wait_rise("spin_edges", 1, 40, 0, 0, 8);
      step_check("spin_done", 0, exp_v(0, 0, 1, 0, 3'd5, 16'd0));
      wif.lock    = 1'b0;
      wif.drained = 1'b0;
      step_check("cycle_end", 1, exp_v(0, 0, 0, 0, 3'd0, 16'd0));

      // Pause: motor low for 5 edges mid-wash
      do_reset("rst_pause");
      to_wash();
      wait_rise("pause_edges", 0, 40, 2, 5, 17);

      // Drain watchdog
      do_reset("rst_wdog");
      to_wash();
      wait_rise("wdog_wash", 0, 40, 0, 0, 12);
      wif.motor = 1'b0;
      step(1);
      wif.drain_valve = 1'b1;
      wait_rise("wdog_edges", 2, 40, 0, 0, 8);
      step_check("fault_state", 0, exp_v(1, 0, 0, 0, 3'd6, 16'd0));
      wif.lock = 1'b0;
      step_check("fault_lock0", 1, exp_v(1, 0, 0, 0, 3'd6, 16'd0));
      wif.lock  = 1'b1;
      wif.motor = 1'b1;
      step_check("fault_lock1", 1, exp_v(1, 0, 0, 0, 3'd6, 16'd0));
      wif.lock = 1'b0;
      step_check("fault_sticky", 3, exp_v(1, 0, 0, 0, 3'd6, 16'd0));
      do_reset("fault_cleared");

      // Priority: drained on the same edge as the second drain tick
      to_wash();
      wait_rise("prio_wash", 0, 40, 0, 0, 12);
      wif.motor = 1'b0;
      step(1);
      wif.drain_valve = 1'b1;
      step_check("drain_tick1", 4, exp_v(0, 0, 0, 0, 3'd3, 16'd1));
      step(3);
      wif.drained = 1'b1;
      step_check("prio_drained", 1, exp_v(0, 1, 0, 0, 3'd4, 16'd2));

      // Abort mid-wash
      do_reset("rst_abort");
      to_wash();
      step(5);
      wif.lock = 1'b0;
      step_check("abort", 1, exp_v(0, 0, 0, 0, 3'd0, 16'd0));
      wait_rise("abort_no_timeout", 0, 20, 0, 0, -1);

      // Asynchronous reset mid-spin
      do_reset("rst_async_prep");
      to_wash();
      wait_rise("async_wash", 0, 40, 0, 0, 12);
      wif.motor = 1'b0;
      step(1);
      wif.drained = 1'b1;
      step(1);
      step_check("spin_mid", 2, exp_v(0, 1, 0, 0, 3'd4, 16'd2));
      #3;
      rst = 1'b0;
      step_check("async_rst", 0, exp_v(0, 0, 0, 0, 3'd0, 16'd0));
      @(negedge clk);
      rst             = 1'b1;
      wif.lock        = 1'b0;
      wif.motor       = 1'b0;
      wif.drained     = 1'b0;
      wif.drain_valve = 1'b0;
      step_check("after_release", 1, exp_v(0, 0, 0, 0, 3'd0, 16'd0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
